// File: rtl/pipe_pkg.sv
// pipe_pkg
// Shared constants and types for the pipe_stage_chain register chain.
//   DEF_STAGES / DEF_DATA_W : default chain depth and payload width
//   KILL_W                  : width of the saturating flush-kill counter
//   idx_t                   : stage index type for the default depth
package pipe_pkg;

  localparam int DEF_STAGES = 4;
  localparam int DEF_DATA_W = 64;
  localparam int KILL_W     = 16;
  localparam int DEF_IDX_W  = $clog2(DEF_STAGES);

  typedef logic [DEF_IDX_W-1:0] idx_t;
  typedef logic [KILL_W-1:0]    kill_cnt_t;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// One stage of the chain: a valid bit plus a payload register.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture din and mark the stage valid
//   clr        : mark the stage empty (wins over load, payload untouched)
//   din        : payload to capture on load
//   v, d       : current valid bit and payload
// When neither load nor clr is asserted the stage holds.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [DATA_W-1:0] din,
  output logic              v,
  output logic [DATA_W-1:0] d
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v <= 1'b0;
      d <= '0;
    end else if (clr) begin
      // Bubble or flush: payload is left as-is, only the valid bit drops.
      v <= 1'b0;
    end else if (load) begin
      v <= 1'b1;
      d <= din;
    end
  end

endmodule

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// In-order pipeline register chain with elastic valid/ready handshake,
// per-stage stall, bubble collapse and flush of the younger stages.
// Stage 0 is the youngest (input side), stage STAGES-1 the oldest (output).
//   clk, reset             : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : upstream handshake into stage 0
//   out_valid/out_ready/out_data : downstream handshake from the last stage
//   stall_req[k]           : hold stage k in place
//   flush_valid/flush_stage: kill stages 0..flush_stage this cycle
//   occupancy              : registered count of valid stages
//   kill_count             : registered, saturating count of flushed items
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = $clog2(STAGES),
  parameter int CNT_W  = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic [STAGES-1:0] stall_req,
  input  logic              flush_valid,
  input  logic [IDX_W-1:0]  flush_stage,
  output logic [CNT_W-1:0]  occupancy,
  output logic [KILL_W-1:0] kill_count
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] space;
  logic [STAGES-1:0] killed;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] clr;
  logic [STAGES-1:0] v_nxt;
  logic [DATA_W-1:0] d   [STAGES];
  logic [DATA_W-1:0] din [STAGES];
  logic [IDX_W-1:0]  fs_eff;
  logic [CNT_W-1:0]  kills;

  function automatic logic [CNT_W-1:0] popcnt(input logic [STAGES-1:0] x);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STAGES; i++) begin
      c = c + CNT_W'(x[i]);
    end
    return c;
  endfunction

  function automatic logic [KILL_W-1:0] sat_add(input logic [KILL_W-1:0] a,
                                                input logic [CNT_W-1:0]  b);
    logic [KILL_W:0] s;
    s = {1'b0, a} + (KILL_W + 1)'(b);
    return s[KILL_W] ? {KILL_W{1'b1}} : s[KILL_W-1:0];
  endfunction

  // Out-of-range flush index behaves as a flush of the whole chain.
  always_comb begin
    if (int'(flush_stage) >= STAGES) fs_eff = IDX_W'(STAGES - 1);
    else                             fs_eff = flush_stage;
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      killed[k] = flush_valid & (k <= int'(fs_eff));
    end
  end

  // Advance/space ripple from the oldest stage back to the youngest so a
  // stage can refill in the same cycle the stage ahead of it drains.
  always_comb begin
    adv   = '0;
    space = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (k == STAGES - 1) adv[k] = v[k] & ~stall_req[k] & ~killed[k] & out_ready;
      else                 adv[k] = v[k] & ~stall_req[k] & space[k+1];
      space[k] = ~v[k] | adv[k];
    end
  end

  assign in_ready  = space[0] & ~flush_valid;
  assign out_valid = v[STAGES-1] & ~stall_req[STAGES-1] & ~killed[STAGES-1];
  assign out_data  = d[STAGES-1];

  // Per-stage load/clear. An item leaving a killed stage is never loaded,
  // so the stage just above the flush boundary receives a bubble.
  always_comb begin
    load = '0;
    clr  = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) load[k] = in_valid & in_ready;
      else        load[k] = adv[k-1] & ~killed[k-1];
      clr[k] = killed[k] | (~load[k] & (adv[k] | ~v[k]));
    end
  end

  always_comb begin
    din[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      din[k] = d[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_nxt[k] = clr[k] ? 1'b0 : (load[k] ? 1'b1 : v[k]);
    end
  end

  assign kills = popcnt(v & killed);

  // ---- stage registers ----
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_stage_reg #(
      .DATA_W (DATA_W)
    ) u_reg (
      .clk   (clk),
      .reset (reset),
      .load  (load[k]),
      .clr   (clr[k]),
      .din   (din[k]),
      .v     (v[k]),
      .d     (d[k])
    );
  end

  // ---- status registers ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occupancy  <= '0;
      kill_count <= '0;
    end else begin
      occupancy  <= popcnt(v_nxt);
      kill_count <= sat_add(kill_count, kills);
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Scoreboard bench for pipe_stage_chain: accepted items are queued, a
// monitor pops and compares every output handshake.
module tb_pipe_stage_chain;

  localparam int STAGES = 4;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 2;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [STAGES-1:0] stall_req;
  logic              flush_valid;
  logic [IDX_W-1:0]  flush_stage;
  logic [CNT_W-1:0]  occupancy;
  logic [15:0]       kill_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int kill_n = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  pipe_stage_chain #(
    .STAGES (STAGES),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .stall_req   (stall_req),
    .flush_valid (flush_valid),
    .flush_stage (flush_stage),
    .occupancy   (occupancy),
    .kill_count  (kill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected-value producer: accepted items enter the queue, flushed ones
  // (the kill_n youngest) leave it from the back.
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) exp_q.push_back(in_data);
    if (!reset && flush_valid) begin
      for (int i = 0; i < kill_n; i++) void'(exp_q.pop_back());
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_unexpected: got %0h expected nothing", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("out_data", out_data, mon_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_item(input logic [63:0] data);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = data;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 64'(ok), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] nxt;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    stall_req = '0; flush_valid = 1'b0; flush_stage = '0;

    // Reset state
    tick();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_kill_count", 64'(kill_count), 64'(0));
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // Stream 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'h10 + 64'(i);
      tick();
      if (i == 2) chk("lat_not_yet", 64'(out_valid), 64'(0));
      if (i == 3) begin
        chk("lat_valid", 64'(out_valid), 64'(1));
        chk("lat_data", out_data, 64'h10);
        chk("stream_occ_a", 64'(occupancy), 64'(4));
      end
      if (i == 7) chk("stream_occ_b", 64'(occupancy), 64'(4));
    end
    in_valid = 1'b0;
    repeat (5) tick();
    chk("stream_empty", 64'(occupancy), 64'(0));

    // Backpressure with a full chain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_item(64'h10 + 64'(i));
    in_valid = 1'b1;
    in_data  = 64'h99;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_occ", 64'(occupancy), 64'(4));
      chk("bp_out_data", out_data, 64'h10);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("drain_valid", 64'(out_valid), 64'(1));
      chk("drain_data", out_data, 64'h10 + 64'(j));
      tick();
    end
    @(negedge clk);
    chk("drain_done", 64'(out_valid), 64'(0));
    tick();

    // Stall stage 1 for two cycles while streaming 0x20..0x2B
    nxt = 64'h20;
    for (int c = 0; c < 16; c++) begin
      stall_req = (c == 6 || c == 7) ? 4'b0010 : 4'b0000;
      in_valid  = (nxt <= 64'h2B);
      in_data   = nxt;
      @(negedge clk);
      if (c == 6 || c == 7) begin
        chk("stall_in_ready", 64'(in_ready), 64'(0));
        chk("stall_out_valid", 64'(out_valid), 64'(1));
      end
      if (c == 8 || c == 9) chk("stall_bubble", 64'(out_valid), 64'(0));
      if (c == 10) chk("stall_resume", 64'(out_valid), 64'(1));
      if (in_valid && in_ready) nxt = nxt + 64'd1;
      tick();
    end
    stall_req = '0;
    in_valid  = 1'b0;
    repeat (6) tick();

    // Flush stages 0..1 on a full chain A1..A4
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_item(64'hA0 + 64'(i));
    flush_valid = 1'b1; flush_stage = 2'd1; kill_n = 2;
    @(negedge clk);
    chk("fl1_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush_valid = 1'b0;
    chk("fl1_occ", 64'(occupancy), 64'(2));
    chk("fl1_kills", 64'(kill_count), 64'(2));
    chk("fl1_head", out_data, 64'hA1);
    out_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("fl1_empty", 64'(out_valid), 64'(0));
    tick();

    // Flush the whole chain with out_ready high
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_item(64'hB0 + 64'(i));
    flush_valid = 1'b1; flush_stage = 2'd3; kill_n = 4; out_ready = 1'b1;
    @(negedge clk);
    chk("fl3_out_valid", 64'(out_valid), 64'(0));
    tick();
    flush_valid = 1'b0;
    chk("fl3_occ", 64'(occupancy), 64'(0));
    chk("fl3_kills", 64'(kill_count), 64'(6));

    // Flush stage 0 while the output handshake completes
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_item(64'hC0 + 64'(i));
    flush_valid = 1'b1; flush_stage = 2'd0; kill_n = 1; out_ready = 1'b1;
    @(negedge clk);
    chk("fl0_out_valid", 64'(out_valid), 64'(1));
    chk("fl0_in_ready", 64'(in_ready), 64'(0));
    tick();
    flush_valid = 1'b0;
    chk("fl0_kills", 64'(kill_count), 64'(7));
    chk("fl0_occ", 64'(occupancy), 64'(2));
    repeat (3) tick();
    chk("fl0_empty", 64'(out_valid), 64'(0));
    kill_n = 0;

    // Reset with three items in flight
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) send_item(64'hD0 + 64'(i));
    reset = 1'b1;
    #1;
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_occ", 64'(occupancy), 64'(0));
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    chk("mrst_kills", 64'(kill_count), 64'(0));
    chk("mrst_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    send_item(64'hE1);
    repeat (5) tick();

    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("emitted_total", 64'(n_out), 64'(30));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
# pipe_stage_chain

Parametrised in-order pipeline register chain with an elastic valid/ready handshake, per-stage stall, bubble collapse, and targeted flush of younger stages. It replaces the fixed IF_ID / ID_EX / EX_MEM / MEM_WB registers in the pipelined processor. Hazard logic drives stall and flush requests, and the datapath packs each stage's payload into one `DATA_W` vector. Stage 0 is the youngest and receives input; stage `STAGES-1` is the oldest and drives the output.

## Interface
- `STAGES`, 4, number of register stages (≥2).
- `DATA_W`, 64, payload width per stage.
- `IDX_W`, `$clog2(STAGES)`, stage-index width (derived).
- `CNT_W`, `$clog2(STAGES+1)`, occupancy width (derived).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream presents an item.
- `in_ready`  out  1  stage 0 accepts the item this cycle.
- `in_data`  in  `DATA_W`  upstream payload.
- `out_valid`  out  1  oldest stage presents an item.
- `out_ready`  in  1  downstream consumes the item.
- `out_data`  out  `DATA_W`  payload of stage `STAGES-1`.
- `stall_req`  in  `STAGES`  bit k holds stage k in place.
- `flush_valid`  in  1  flush request this cycle.
- `flush_stage`  in  `IDX_W`  kill stages 0..flush_stage inclusive.
- `occupancy`  out  `CNT_W`  registered count of valid stages.
- `kill_count`  out  16  registered count of items killed by flushes; saturates at 0xFFFF.

## Operation
- Each stage k holds `v[k]` and `d[k]`.
- `adv[k]` = `v[k]` & !`stall_req[k]` & (k==STAGES-1 ? `out_ready` : `space[k+1]`).
- `space[k]` = !`v[k]` | `adv[k]`. This lets items collapse into bubbles and gives full throughput while flowing.
- `in_ready` = `space[0]` & !`flush_valid`.
- `out_valid` = `v[STAGES-1]` & !`stall_req[STAGES-1]` & !(`flush_valid` & `flush_stage`==STAGES-1).
- Stage k+1 load: when `adv[k]`, `d[k+1]`←`d[k]` and `v[k+1]`←1.
  - Otherwise, if `adv[k+1]` or stage k+1 was empty, `v[k+1]`←0 (bubble inserted behind a stalled stage).
  - Otherwise stage k+1 holds.
- Stage 0 loads on `in_valid` & `in_ready`. Data registers load only when a valid item enters; they are not cleared on bubble.
- Flush has priority over stall and advance for stages 0..`flush_stage`: their `v` clears next edge.
  - Items advancing out of stage `flush_stage` into stage `flush_stage+1` that cycle are killed. Stage `flush_stage+1` receives a bubble instead.
  - Stages above `flush_stage` behave normally.
- `kill_count` += number of stages in 0..`flush_stage` that were valid when the flush was sampled.
- `flush_stage` ≥ STAGES is invalid; treat it as STAGES-1.
- `occupancy` = popcount of next-state `v`, registered.

## Timing
- Reset: all `v`=0, all `d`=0, `occupancy`=0, `kill_count`=0, `out_valid`=0, `out_data`=0.
  - `in_ready`=1 while reset is deasserted and there is no flush.
  - Reset mid-operation drops all items without counting kills.
- Latency: an item accepted at edge n is visible on `out_data` / `out_valid` after edge n+STAGES-1, given no stalls. One item per cycle sustained throughput.
- `in_ready` and `out_valid` are combinational from `stall_req`, `flush_*` and `out_ready`. No combinational path exists from `in_valid` to `out_valid`.
- Full chain with `out_ready`=1: accept and emit in the same cycle.
- Full chain with `out_ready`=0: `in_ready`=0.
- Simultaneous flush and `out_ready`: if `flush_stage`<STAGES-1, the output handshake completes normally.

## Structure
- Package `pipe_pkg`: default `STAGES`/`DATA_W` constants, the `kill_count` width, and an `idx_t` typedef.
- Sub-module `pipe_stage_reg`: one stage holding `v` and `d` with load, clear and hold controls and async reset. Generated STAGES times; the chain logic lives in the top.

## Test plan
- Stream 0x10..0x17 with `out_ready`=1 and no stalls -> first `out_valid` 3 cycles after first accept, values in order, one per cycle, `occupancy` steady at 4.
- Fill the chain, hold `out_ready`=0 for 5 cycles -> `in_ready`=0, `occupancy`=4, `out_data`=0x10 stable; release -> 0x10..0x13 drain in consecutive cycles.
- `stall_req`=4'b0010 for 2 cycles during streaming -> stages 0–1 hold, a bubble appears at stage 2, `out_valid` drops for 2 cycles, no item lost or duplicated.
- Full chain with items A,B,C,D (stage 0=D): flush with `flush_stage`=1 -> next cycle D and C are gone, A and B emit, `kill_count`=2, `in_ready`=0 in the flush cycle.
- Flush `flush_stage`=3 with `out_ready`=1 -> `out_valid`=0 that cycle, chain empty next cycle, `kill_count` += number of valid stages.
- Assert `reset` mid-stream with 3 items in flight -> `out_valid`=0 and `occupancy`=0 immediately, `kill_count` unchanged at 0 after release.
